instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 REQ_VALID  input  1  an instruction request is present.
REQ-005 REQ_READY  output  1  the block can accept a request this cycle.
REQ-006 REQ_OP  input  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LD, 7 ST, 15 NOP, 8-14 illegal.
REQ-007 REQ_REG  input  2  register operand: 00 R0, 01 R1, 10 R2, 11 RZ.
REQ-008 STALL  input  1  when high, holds issue to the downstream decoder.
REQ-009 INSTR  output  6  encoded instruction word {opcode[3:0], adR[1:0]}, fed to the decoder DATA input.
REQ-010 INSTR_VALID  output  1  INSTR carries a dequeued request this cycle.
REQ-011 ERR  output  1  sticky flag for an illegal request.

Function
REQ-012 Encoding: REQ_OP 0-7 SHALL give opcode {1'b0, REQ_OP[2:0]} and adR = REQ_REG; REQ_OP 15 SHALL give 6'b111111 regardless of REQ_REG.
REQ-013 A request is accepted when REQ_VALID and REQ_READY are both high at a rising edge; the encoded word is written to a 4-entry FIFO.
REQ-014 REQ_READY SHALL be high when the registered FIFO count is less than 4. It SHALL NOT depend combinationally on STALL or on a pop in the same cycle.
REQ-015 When the FIFO is non-empty and STALL is low at an edge, the head entry SHALL be popped into the INSTR register and INSTR_VALID is set to 1 for the following cycle.
REQ-016 When the FIFO is empty or STALL is high, the next INSTR SHALL be 6'b111111 (NOP) with INSTR_VALID 0.
REQ-017 Issue rate SHALL be at most one instruction per cycle, in strict acceptance order.
REQ-018 Latency: a request accepted at edge N into an empty FIFO with STALL low SHALL appear on INSTR after edge N+1. There is no bypass path.
REQ-019 A push and a pop in the same cycle SHALL leave the count unchanged. The count SHALL never exceed 4 or drop below 0.
REQ-020 FIFO read and write pointers SHALL be 2 bits and wrap from 3 to 0.
REQ-021 STALL SHALL NOT affect acceptance; requests continue to fill the FIFO until it is full.

Reset
REQ-022 RST SHALL clear the FIFO count and both pointers, set INSTR=6'b111111, set INSTR_VALID=0 and ERR=0, and give REQ_READY=1 on the cycle after release.
REQ-023 RST asserted mid-burst SHALL discard all queued entries. No queued instruction SHALL issue after reset.
REQ-024 RST SHALL take priority over a simultaneous push or pop.

Configuration
REQ-025 Macro ENC_ILLEGAL_CHECK_EN SHALL control illegal-request handling.
REQ-026 With ENC_ILLEGAL_CHECK_EN defined:
  - Illegal requests are REQ_OP 8-14, and REQ_OP 7 (ST) with REQ_REG=11 (RZ).
  - Such a request SHALL be accepted by the handshake but not enqueued.
  - ERR SHALL be set to 1 on the following cycle and hold until RST.
REQ-027 Without ENC_ILLEGAL_CHECK_EN:
  - REQ_OP 8-14 SHALL be enqueued as 6'b111111.
  - ST RZ SHALL be enqueued as 6'b011111.
  - ERR SHALL be tied to 0.

Verification
REQ-028 Hold RST high for 2 cycles -> INSTR=6'b111111, INSTR_VALID=0, REQ_READY=1, ERR=0.
REQ-029 Present REQ_OP=0, REQ_REG=01 for one cycle with STALL=0 -> INSTR=6'b000001 with INSTR_VALID=1 for exactly one cycle, 2 edges after the request; then NOP with INSTR_VALID=0.
REQ-030 With STALL=1, present 5 back-to-back requests (ADD R0, SUB R1, LD R2, XOR RZ, NOT R0):
  - REQ_READY=0 on the 5th request, which is held.
  - Release STALL -> words 000000, 000101, 011010, 010011, 010100 issue on consecutive cycles.
  - REQ_READY returns to 1 the cycle after the first pop, and the 5th request then issues.
REQ-031 Present ST R2 (REQ_OP=7, REQ_REG=10) -> INSTR=6'b011110 with INSTR_VALID=1, and ERR stays 0.
REQ-032 Present ST RZ:
  - With the macro defined: nothing issues and ERR=1.
  - Without the macro: 6'b011111 issues with INSTR_VALID=1 and ERR=0.
REQ-033 Queue 3 requests with STALL=1, assert RST for one cycle, then drop STALL -> INSTR_VALID stays 0 and the count is 0.

Source files
------------

// File: rtl/instruction_encoder.sv
// Instruction encoder: encodes mnemonic/register requests into 6-bit words and issues them
// through a 4-entry FIFO. Define ENC_ILLEGAL_CHECK_EN to reject illegal requests and flag ERR.
module instruction_encoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [1:0] req_reg,
   input  logic       stall,
   output logic [5:0] instr,
   output logic       instr_valid,
   output logic       err
);

   localparam logic [5:0] NOP_WORD = 6'b111111;

   // Returns {legal, word}; only ST RZ and opcodes 8-14 ever depend on the illegal-check build
   function automatic logic [6:0] encode(input logic [3:0] op, input logic [1:0] rg);
      logic [6:0] res;
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: res = {1'b1, 1'b0, op[2:0], rg};
`ifdef ENC_ILLEGAL_CHECK_EN
         4'd7:    res = (rg == 2'b11) ? {1'b0, NOP_WORD} : {1'b1, 4'b0111, rg};
         4'd15:   res = {1'b1, NOP_WORD};
         default: res = {1'b0, NOP_WORD};
`else
         4'd7:    res = {1'b1, 4'b0111, rg};
         4'd15:   res = {1'b1, NOP_WORD};
         default: res = {1'b1, NOP_WORD};
`endif
      endcase
      return res;
   endfunction

   logic [5:0] fifo_r [4];
   logic [1:0] wr_ptr_r;
   logic [1:0] rd_ptr_r;
   logic [2:0] count_r;
   logic       req_ready_r;
   logic [5:0] instr_r;
   logic       instr_valid_r;
   logic       err_r;

   logic [6:0] enc_s;
   logic       accept_s;
   logic       push_s;
   logic       pop_s;
   logic [2:0] count_next_s;

   // Handshake, push/pop qualification and next FIFO occupancy
   always_comb begin
      enc_s    = encode(req_op, req_reg);
      accept_s = req_valid & req_ready_r;
      push_s   = accept_s & enc_s[6];
      pop_s    = (count_r != 3'd0) & ~stall;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + 3'd1;
         2'b01:   count_next_s = count_r - 3'd1;
         default: count_next_s = count_r;
      endcase
   end

   // FIFO storage; contents are don't-care until the count covers them
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= enc_s[5:0];
      end else begin
         fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
      end
   end

   // Pointers, occupancy, issue register and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r      <= 2'd0;
         rd_ptr_r      <= 2'd0;
         count_r       <= 3'd0;
         req_ready_r   <= 1'b1;
         instr_r       <= NOP_WORD;
         instr_valid_r <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         count_r       <= count_next_s;
         // Ready registered from next count so it never sees STALL or a pop combinationally
         req_ready_r   <= (count_next_s < 3'd4);
         instr_r       <= pop_s ? fifo_r[rd_ptr_r] : NOP_WORD;
         instr_valid_r <= pop_s;
`ifdef ENC_ILLEGAL_CHECK_EN
         if (accept_s && !enc_s[6]) begin
            err_r <= 1'b1;
         end
`else
         err_r         <= 1'b0;
`endif
      end
   end

   assign req_ready   = req_ready_r;
   assign instr       = instr_r;
   assign instr_valid = instr_valid_r;
   assign err         = err_r;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder; ENC_ILLEGAL_CHECK_EN selects the
// illegal-request expectations.
module tb_instruction_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [1:0] req_reg;
   logic       stall;
   logic [5:0] instr;
   logic       instr_valid;
   logic       err;

   int total = 0;
   int bad   = 0;

   instruction_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_reg     (req_reg),
      .stall       (stall),
      .instr       (instr),
      .instr_valid (instr_valid),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; stall = 1'b0; req_op = 4'd15; req_reg = 2'd0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (instr !== 6'b111111) begin bad++; $display("FAIL reset_instr got=%b exp=111111", instr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      step();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_single();
      req_valid = 1'b1; req_op = 4'd0; req_reg = 2'b01;
      step();
      req_valid = 1'b0;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", instr_valid); end
      step();
      total++; if (instr !== 6'b000001 || instr_valid !== 1'b1) begin bad++; $display("FAIL single_issue got=%b/%b exp=000001/1", instr, instr_valid); end
      step();
      total++; if (instr !== 6'b111111 || instr_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b/%b exp=111111/0", instr, instr_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops   [5] = '{4'd0, 4'd1, 4'd6, 4'd4, 4'd5};
      logic [1:0] regs  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [5:0] words [5] = '{6'b000000, 6'b000101, 6'b011010, 6'b010011, 6'b010100};
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_op = ops[i]; req_reg = regs[i];
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, req_ready); end
         step();
      end
      req_op = ops[4]; req_reg = regs[4];
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", req_ready); end
      step();
      total++; if (req_ready !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_stalled got=%b/%b exp=0/0", req_ready, instr_valid); end
      stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 0) begin
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%b exp=1", req_ready); end
         end
         if (k == 1) req_valid = 1'b0;
         total++; if (instr !== words[k] || instr_valid !== 1'b1) begin bad++; $display("FAIL b2b_word_%0d got=%b/%b exp=%b/1", k, instr, instr_valid, words[k]); end
      end
      step();
      total++; if (instr !== 6'b111111 || instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b/%b exp=111111/0", instr, instr_valid); end
   endtask

   task automatic test_store();
      req_valid = 1'b1; req_op = 4'd7; req_reg = 2'b10;
      step();
      req_valid = 1'b0;
      step();
      total++; if (instr !== 6'b011110 || instr_valid !== 1'b1) begin bad++; $display("FAIL st_r2 got=%b/%b exp=011110/1", instr, instr_valid); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL st_r2_err got=%b exp=0", err); end
      req_valid = 1'b1; req_op = 4'd15; req_reg = 2'b01;
      step();
      req_valid = 1'b0;
      step();
      total++; if (instr !== 6'b111111 || instr_valid !== 1'b1) begin bad++; $display("FAIL nop_req got=%b/%b exp=111111/1", instr, instr_valid); end
   endtask

   task automatic test_illegal();
      req_valid = 1'b1; req_op = 4'd7; req_reg = 2'b11;
      step();
      req_valid = 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      total++; if (err !== 1'b1) begin bad++; $display("FAIL st_rz_err got=%b exp=1", err); end
      step();
      total++; if (instr_valid !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL st_rz_drop got=%b/%b exp=0/1", instr_valid, err); end
`else
      step();
      total++; if (instr !== 6'b011111 || instr_valid !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL st_rz got=%b/%b/%b exp=011111/1/0", instr, instr_valid, err); end
`endif
      req_valid = 1'b1; req_op = 4'd9; req_reg = 2'b01;
      step();
      req_valid = 1'b0;
      step();
`ifdef ENC_ILLEGAL_CHECK_EN
      total++; if (instr_valid !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL op9 got=%b/%b exp=0/1", instr_valid, err); end
`else
      total++; if (instr !== 6'b111111 || instr_valid !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL op9 got=%b/%b/%b exp=111111/1/0", instr, instr_valid, err); end
`endif
   endtask

   task automatic test_reset_mid_burst();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_op = 4'(i); req_reg = 2'b01;
         step();
      end
      req_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0; stall = 1'b0;
      total++; if (req_ready !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=%b/%b exp=1/0", req_ready, err); end
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_issue_%0d got=%b exp=0", i, instr_valid); end
      end
      // Empty count: exactly four more requests must fit before ready drops
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_op = 4'd2; req_reg = 2'd0;
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_cnt_%0d got=%b exp=1", i, req_ready); end
         step();
      end
      req_valid = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_full got=%b exp=0", req_ready); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_store();
      test_illegal();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
